// File: rtl/binario_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding and
// the shift-and-add-3 digit constants.
package binario_bcd_pkg;

   typedef enum logic {
      OCIOSO  = 1'b0,
      DESLOCA = 1'b1
   } estado_t;

   // Width of one BCD digit
   localparam int DIGITO_W = 4;
   // A digit at or above this value would overflow past 9 after the next
   // doubling, so it is corrected first
   localparam int LIMIAR   = 5;
   // Correction added to such a digit
   localparam int OFFSET   = 3;

endpackage

// File: rtl/binario_bcd_ajuste.sv
// Combinational per-digit correction of the shift-and-add-3 algorithm:
// adds 3 to a digit of 5 or more so the following left shift carries
// correctly into the next decimal digit.
module ajuste_bcd
   import binario_bcd_pkg::*;
(
   input  logic [DIGITO_W-1:0] d,
   output logic [DIGITO_W-1:0] q
);

   // Conditional +3 correction
   always_comb begin
      q = d;
      if (d >= DIGITO_W'(LIMIAR)) begin
         q = d + DIGITO_W'(OFFSET);
      end
   end

endmodule

// File: rtl/binario_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock. Accepts an
// unsigned N-bit value on an inicio request, and after N shift cycles
// publishes D packed BCD digits on bcd with a one-cycle pronto pulse.
// bcd is held between completions so the 7-segment decoders see only
// final results.
module binario_bcd
   import binario_bcd_pkg::*;
#(
   parameter int N = 8,
   parameter int D = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inicio,
   input  logic [N-1:0]          e,
   output logic                  ocupado,
   output logic                  pronto,
   output logic [DIGITO_W*D-1:0] bcd
);

   localparam int CW = $clog2(N + 1);
   localparam int BW = DIGITO_W * D;

   estado_t        estado;
   logic [N-1:0]   desl;       // binary shift register, MSB leaves first
   logic [BW-1:0]  digitos;    // scratch digits, never visible on bcd
   logic [BW-1:0]  ajustado;   // scratch digits after the +3 correction
   logic [BW-1:0]  deslocado;  // corrected digits shifted left, binary MSB in
   logic [CW-1:0]  cont;       // shifts still to perform

   // One corrector per digit, all applied in parallel before the shift
   for (genvar i = 0; i < D; i++) begin : g_ajuste
      ajuste_bcd u_ajuste (
         .d (digitos [i*DIGITO_W +: DIGITO_W]),
         .q (ajustado[i*DIGITO_W +: DIGITO_W])
      );
   end

   assign deslocado = {ajustado[BW-2:0], desl[N-1]};

   // Busy is simply the conversion state
   assign ocupado = (estado == DESLOCA);

   // Conversion FSM with shift datapath and registered result/pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado  <= OCIOSO;
         desl    <= '0;
         digitos <= '0;
         cont    <= '0;
         bcd     <= '0;
         pronto  <= 1'b0;
      end else begin
         pronto <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (inicio) begin
                  desl    <= e;
                  digitos <= '0;
                  cont    <= CW'(N);
                  estado  <= DESLOCA;
               end
            end
            DESLOCA: begin
               digitos <= deslocado;
               desl    <= {desl[N-2:0], 1'b0};
               cont    <= cont - CW'(1);
               // Last shift: publish the digits and return to idle; a new
               // inicio during the pronto cycle is accepted from OCIOSO
               if (cont == CW'(1)) begin
                  bcd    <= deslocado;
                  pronto <= 1'b1;
                  estado <= OCIOSO;
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_binario_bcd.sv
// Testbench for binario_bcd (N=8, D=3): directed scenarios plus randomized
// and exhaustive conversions compared against a decimal-arithmetic model.
module tb_binario_bcd;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        inicio = 1'b0;
   logic [7:0]  e      = 8'd0;
   logic        ocupado;
   logic        pronto;
   logic [11:0] bcd;

   int errors = 0;
   int checks = 0;

   binario_bcd #(.N(8), .D(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inicio  (inicio),
      .e       (e),
      .ocupado (ocupado),
      .pronto  (pronto),
      .bcd     (bcd)
   );

   always #5 clk = ~clk;

   // Reference: decimal digits of v by plain division
   function automatic logic [11:0] ref_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'((v / 100) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Starts a conversion from idle (called #1 after an edge) and checks
   // latency, busy duration, result and the single-cycle pulse. e is
   // scrambled during the conversion to show it is ignored.
   task automatic converte(input logic [7:0] v, input string tag);
      int lat;
      int busy;
      logic [11:0] exp_bcd;
      exp_bcd = ref_bcd(int'(v));
      inicio = 1'b1;
      e      = v;
      @(posedge clk); #1;
      inicio = 1'b0;
      e      = 8'($urandom);
      busy   = ocupado ? 1 : 0;
      lat    = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         e = 8'($urandom);
         if (pronto) break;
         if (ocupado) busy++;
      end
      check({tag, " latency"}, lat, 8);
      check({tag, " busy cycles"}, busy, 8);
      check({tag, " bcd"}, int'(bcd), int'(exp_bcd));
      check({tag, " ocupado at done"}, int'(ocupado), 0);
      @(posedge clk); #1;
      check({tag, " pronto drop"}, int'(pronto), 0);
      check({tag, " bcd held"}, int'(bcd), int'(exp_bcd));
   endtask

   initial begin
      int pos[$];
      int dupl;
      int lat;
      int npr;
      int d0, d1, d2;
      logic prev;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset ocupado", int'(ocupado), 0);
      check("reset pronto", int'(pronto), 0);
      check("reset bcd", int'(bcd), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle ocupado", int'(ocupado), 0);

      // Directed values
      converte(8'd0,   "e=0");
      converte(8'd255, "e=255");
      converte(8'd31,  "e=31");
      converte(8'd9,   "e=9");
      converte(8'd10,  "e=10");

      // inicio held high: completions every 9 cycles, one-cycle pulses
      inicio = 1'b1;
      e      = 8'd100;
      prev   = 1'b0;
      dupl   = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (pronto) begin
            pos.push_back(k);
            check("held bcd", int'(bcd), 'h100);
            if (prev) dupl++;
         end
         prev = pronto;
      end
      inicio = 1'b0;
      check("held pronto count", pos.size(), 4);
      check("held pronto width", dupl, 0);
      for (int i = 0; i < pos.size(); i++) begin
         check("held pronto spacing", pos[i], 8 + 9 * i);
      end
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (!ocupado && !pronto) break;
      end
      check("held drained", int'(ocupado), 0);

      // Request during conversion is dropped
      inicio = 1'b1;
      e      = 8'd200;
      @(posedge clk); #1;            // t0
      inicio = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;         // t1, t2
      end
      inicio = 1'b1;
      e      = 8'd7;
      @(posedge clk); #1;            // t3 samples the ignored request
      inicio = 1'b0;
      lat = 3;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (pronto) break;
      end
      check("ignore latency", lat, 8);
      check("ignore bcd", int'(bcd), 'h200);
      npr = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (pronto) npr++;
      end
      check("ignore single pronto", npr, 0);
      check("ignore ocupado", int'(ocupado), 0);

      // Asynchronous reset mid-conversion
      inicio = 1'b1;
      e      = 8'd123;
      @(posedge clk); #1;            // t0
      inicio = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort bcd", int'(bcd), 0);
      check("abort ocupado", int'(ocupado), 0);
      check("abort pronto", int'(pronto), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      npr = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (pronto) npr++;
      end
      check("abort no pronto", npr, 0);
      check("abort stays idle", int'(ocupado), 0);
      converte(8'd45, "after abort e=45");

      // Randomized values
      repeat (20) converte(8'($urandom_range(0, 255)), "random");

      // Exhaustive sweep with digit-range and decimal-value checks
      for (int v = 0; v < 256; v++) begin
         converte(8'(v), "sweep");
         d0 = int'(bcd[3:0]);
         d1 = int'(bcd[7:4]);
         d2 = int'(bcd[11:8]);
         check("sweep digits <= 9", int'(d0 <= 9 && d1 <= 9 && d2 <= 9), 1);
         check("sweep value", 100 * d2 + 10 * d1 + d0, v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/binario_bcd.md
# binario_bcd

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the 7-segment decoders of the adder display path. Takes an unsigned N-bit result (e.g. the adder sum plus carry-out), produces D packed BCD digits of 0–9 each, and holds them stable for the per-digit decoders. A start/busy/done handshake with the producing logic; one conversion in flight at a time.

## Interface
- N, default 8: width of the binary input.
- D, default 3: number of BCD output digits. Must satisfy 10^D > 2^N − 1. No overflow detection is provided.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- inicio  input  1  start request, sampled on the rising edge of clk.
- e  input  N  unsigned binary value, captured on the edge that accepts inicio.
- ocupado  output  1  high while a conversion is in progress.
- pronto  output  1  single-cycle pulse; bcd has just been updated.
- bcd  output  4*D  packed digits. bcd[3:0] is the units digit, bcd[7:4] the tens digit, and so on. Registered, held until the next completion.

## Operation
- Two states.
  - OCIOSO is the reset state.
  - DESLOCA is the conversion state.
- OCIOSO:
  - When inicio is 1 on an edge: latch e into the shift register, clear the scratch digits to 0, load the counter with N, and move to DESLOCA.
  - When inicio is 0, stay in OCIOSO.
- DESLOCA, on each edge:
  - First, add 3 to every scratch digit that is ≥ 5. All digits are adjusted in parallel.
  - Then shift the {digits, binary} concatenation left by 1. The binary MSB enters the units-digit LSB.
  - Decrement the counter.
- Completion happens on the edge where the counter reaches 0:
  - The post-shift digits are written to bcd.
  - pronto is set to 1.
  - The state returns to OCIOSO.
- inicio is ignored while ocupado = 1. No queuing; the request is dropped.
- ocupado = 1 exactly when the state is DESLOCA. It is decoded from the state register.
- pronto is registered and is high for exactly one cycle per conversion.
- bcd changes only on a completion edge or on reset. Intermediate scratch values are never visible.
- Every output digit is in the range 0–9 for all legal N/D combinations.

## Timing
- Let t0 be the edge that samples inicio = 1 in OCIOSO.
- ocupado is 1 after t0.
- The shift edges are t1 … tN.
- After tN:
  - bcd holds the result.
  - pronto = 1.
  - ocupado = 0.
- After t(N+1), pronto = 0, unless a new completion occurs on that edge, which is impossible.
- Latency from the accepting edge to valid data is N edges.
- Throughput is one conversion per N+1 cycles.
- A back-to-back start is accepted: inicio = 1 during the pronto cycle is sampled at t(N+1) and starts the next conversion. pronto still drops after t(N+1).
- Reset values: state OCIOSO, ocupado 0, pronto 0, bcd all zeros, internal registers 0.
- Reset asserted mid-conversion aborts immediately and asynchronously:
  - The outputs take their reset values.
  - No pronto pulse is produced.
  - After release, the block waits for a fresh inicio.
- e is don't-care except on the accepting edge. Changes to e during DESLOCA have no effect.

## Structure
- Shared package holds:
  - the state encoding (OCIOSO, DESLOCA);
  - the digit width constant (4);
  - the adjust threshold (5) and offset (3).
- The counter width is $clog2(N+1).
- Sub-module ajuste_bcd, combinational:
  - 4-bit input, 4-bit output.
  - Output is the input + 3 if the input is ≥ 5, otherwise the input unchanged.
  - Instantiated D times via generate.
- Each output nibble connects directly to one 7-segment decoder downstream.

## Test plan
- Reset, then e = 0, inicio pulse → pronto after 8 edges, bcd = 0x000, ocupado high for 8 cycles.
- e = 255 → bcd = 0x255. e = 31 (max adder sum + carry) → bcd = 0x031. e = 9 → bcd = 0x009. e = 10 → bcd = 0x010.
- inicio held high continuously with e = 100 → conversions complete every 9 cycles; each pronto lasts 1 cycle; bcd = 0x100.
- Start with e = 200, then assert inicio with e = 7 at t3 → the second request is ignored; bcd = 0x200; only one pronto.
- Start with e = 123, assert rst_n = 0 at t4 for 1 cycle → bcd = 0x000, ocupado = 0, no pronto. A new start with e = 45 → bcd = 0x045.
- Exhaustive sweep e = 0…255 with a scoreboard: each digit ≤ 9 and 100·d2 + 10·d1 + d0 = e.
